// File: rtl/wb2stream_pkg.sv
// wb2stream_pkg: command codes, frame lengths and sync magic shared by both bridge ends
package wb2stream_pkg;
  typedef enum logic [3:0] {
    CMD_SYNC       = 4'd0,
    CMD_REG_ACCESS = 4'd1,
    CMD_DATA_SET   = 4'd2,
    CMD_DATA_GET   = 4'd3,
    CMD_AUX_CSR    = 4'd4
  } cmd_e;
  typedef enum logic [1:0] {K_WRITE, K_READ, K_AUX, K_SYNC} kind_e;
  localparam int CMD_BYTES = 5;
  localparam int RESP_BYTES = 4;
  localparam logic [31:0] SYNC_MAGIC = 32'hCAFEBABE;
  function automatic logic [39:0] cmd_frame(input cmd_e code, input logic [31:0] payload);
    return {code, 4'h0, payload};
  endfunction
endpackage

// File: rtl/stream_resp_rx.sv
// stream_resp_rx: assembles 4 response bytes MSB first into a word and flags rx_last misplacement
module stream_resp_rx import wb2stream_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  input  logic        rx_valid,
  output logic        done,
  output logic [31:0] word,
  output logic        frame_err
);
  logic [1:0] cnt;
  logic [23:0] sh;
  logic fourth;
  assign fourth = cnt == 2'(RESP_BYTES - 1);
  assign done = en & rx_valid & fourth;
  assign word = {sh, rx_data};
  assign frame_err = en & rx_valid & (rx_last ^ fourth);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      sh <= '0;
    end else if (!en) begin
      cnt <= '0;
    end else if (rx_valid) begin
      cnt <= cnt + 1'b1;
      sh <= {sh[15:0], rx_data};
    end
  end
endmodule

// File: rtl/wb2stream.sv
// wb2stream: bridges local wishbone/aux/sync requests to a remote byte-stream command bridge
module wb2stream import wb2stream_pkg::*; #(
  parameter int TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        wb_we,
  input  logic        wb_cyc,
  output logic        wb_ack,
  input  logic        aux_stb,
  input  logic [31:0] aux_data,
  output logic        aux_busy,
  input  logic        sync_req,
  output logic        sync_ok,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_last,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        resp_err
);
  localparam logic [2:0] LAST_BYTE = 3'(CMD_BYTES - 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, TX_CMD, WAIT_RESP} state_e;
  state_e state;
  kind_e kind;
  logic [2:0] byte_cnt;
  logic seq_idx;
  logic [71:0] rest;
  logic [TW-1:0] tmo;
  logic aux_pend, sync_pend;
  logic go_wb, go_aux, go_sync, tx_hs, last_byte, in_wait;
  logic rx_done, rx_ferr;
  logic [31:0] rx_word, reg_pl;
  logic [79:0] wb_frames;
  assign rx_ready = 1'b1;
  assign in_wait = state == WAIT_RESP;
  assign go_wb = wb_cyc & ~wb_ack;
  assign go_aux = ~go_wb & (aux_stb | aux_pend);
  assign go_sync = ~go_wb & ~go_aux & (sync_req | sync_pend);
  assign tx_hs = tx_valid & tx_ready;
  assign last_byte = byte_cnt == LAST_BYTE && (seq_idx || kind == K_AUX || kind == K_SYNC);
  assign aux_busy = aux_pend | sync_pend | (state != IDLE && (kind == K_AUX || kind == K_SYNC));
  assign reg_pl = {11'h0, ~wb_we, wb_addr};
  // Whole byte sequence is latched at grant, so wb_cyc may drop mid-transaction
  assign wb_frames = wb_we ? {cmd_frame(CMD_DATA_SET, wb_wdata), cmd_frame(CMD_REG_ACCESS, reg_pl)}
                           : {cmd_frame(CMD_REG_ACCESS, reg_pl), cmd_frame(CMD_DATA_GET, 32'h0)};
  stream_resp_rx u_rx (
    .clk(clk), .rst(rst), .en(in_wait), .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid),
    .done(rx_done), .word(rx_word), .frame_err(rx_ferr)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      kind <= K_WRITE;
      byte_cnt <= '0;
      seq_idx <= 1'b0;
      rest <= '0;
      tmo <= '0;
      tx_data <= '0;
      tx_valid <= 1'b0;
      wb_ack <= 1'b0;
      wb_rdata <= '0;
      sync_ok <= 1'b0;
      resp_err <= 1'b0;
      aux_pend <= 1'b0;
      sync_pend <= 1'b0;
    end else begin
      wb_ack <= 1'b0;
      resp_err <= ((rx_valid & ~in_wait) | rx_ferr) ? 1'b1 : (sync_req ? 1'b0 : resp_err);
      aux_pend <= (aux_pend | aux_stb) & ~(state == IDLE & go_aux);
      sync_pend <= (sync_pend | sync_req) & ~(state == IDLE & go_sync);
      case (state)
        IDLE: if (go_wb | go_aux | go_sync) begin
          state <= TX_CMD;
          byte_cnt <= '0;
          seq_idx <= 1'b0;
          tx_valid <= 1'b1;
          kind <= go_wb ? (wb_we ? K_WRITE : K_READ) : (go_aux ? K_AUX : K_SYNC);
          {tx_data, rest} <= go_wb ? wb_frames
                           : {go_aux ? cmd_frame(CMD_AUX_CSR, aux_data) : cmd_frame(CMD_SYNC, 32'h0), 40'h0};
        end
        TX_CMD: if (tx_hs) begin
          {tx_data, rest} <= {rest, 8'h0};
          byte_cnt <= byte_cnt == LAST_BYTE ? 3'd0 : byte_cnt + 1'b1;
          seq_idx <= seq_idx | (byte_cnt == LAST_BYTE);
          if (last_byte) begin
            tx_valid <= 1'b0;
            tmo <= '0;
            state <= (kind == K_READ || kind == K_SYNC) ? WAIT_RESP : IDLE;
            wb_ack <= kind == K_WRITE;
          end
        end
        WAIT_RESP: begin
          tmo <= tmo + 1'b1;
          if (rx_done) begin
            state <= IDLE;
            if (kind == K_READ) begin
              wb_rdata <= rx_word;
              wb_ack <= 1'b1;
            end else sync_ok <= rx_word == SYNC_MAGIC;
          end else if (tmo == TMO_LAST) begin
            state <= IDLE;
            resp_err <= 1'b1;
            if (kind == K_READ) begin
              wb_rdata <= 32'hFFFFFFFF;
              wb_ack <= 1'b1;
            end else sync_ok <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
